// File: rtl/chroma_decimate_fir.sv
// ============================================================================
// Module      : chroma_decimate_fir
// Description : 2:1 horizontal chroma decimator (11-tap symmetric FIR, 8-bit
//               clip), packing output pairs into 16-bit SRAM write words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chroma_decimate_fir #(
    parameter int LINE_WIDTH = 320
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sol,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_eol,
    output logic        sol_err
);

    localparam int c_CNT_W = $clog2(LINE_WIDTH + 1);
    localparam int c_IDX_W = $clog2(LINE_WIDTH / 2);
    localparam logic [c_CNT_W-1:0] c_LINE     = c_CNT_W'(LINE_WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LINE_WIDTH / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_MAC0  = 3'd2,
        S_MAC1  = 3'd3,
        S_MAC2  = 3'd4,
        S_MAC3  = 3'd5,
        S_WRITE = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_win [0:10];
    logic [c_CNT_W-1:0]   r_in_cnt;
    logic [2:0]           r_need;
    logic [c_IDX_W-1:0]   r_idx;
    logic signed [19:0]   r_acc;
    logic [7:0]           r_hold;

    logic                 w_real_avail;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_shift_real;
    logic signed [19:0]   w_c5;
    logic signed [19:0]   w_p46;
    logic signed [19:0]   w_p28;
    logic signed [19:0]   w_p010;
    logic signed [19:0]   w_sum;
    logic [7:0]           w_y;

    assign w_real_avail = (r_in_cnt < c_LINE);

    // Tap pairs are summed before multiplying, exploiting filter symmetry
    assign w_c5   = signed'(20'(r_win[5]));
    assign w_p46  = signed'(20'(r_win[4]) + 20'(r_win[6]));
    assign w_p28  = signed'(20'(r_win[2]) + 20'(r_win[8]));
    assign w_p010 = signed'(20'(r_win[0]) + 20'(r_win[10]));
    assign w_sum  = r_acc + 20'sd21 * w_p010;

    // 131071 is the largest accumulator whose >>>9 still fits in 8 bits
    assign w_y = (w_sum < 20'sd0)      ? 8'd0   :
                 (w_sum > 20'sd131071) ? 8'd255 : w_sum[16:9];

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        in_ready     = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_shift_real = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_sol) begin
                    w_load = 1'b1;
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                in_ready     = w_real_avail;
                w_shift_real = w_real_avail && in_valid;
                // Past the line end the edge sample is replicated once per cycle
                w_shift      = w_shift_real || !w_real_avail;
                if (w_shift && (r_need == 3'd1)) begin
                    w_next = S_MAC0;
                end
            end
            S_MAC0:  w_next = S_MAC1;
            S_MAC1:  w_next = S_MAC2;
            S_MAC2:  w_next = S_MAC3;
            S_MAC3:  w_next = r_idx[0] ? S_WRITE : S_SHIFT;
            S_WRITE: begin
                if (out_ready) begin
                    w_next = out_eol ? S_IDLE : S_SHIFT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 11; k++) begin
                r_win[k] <= 8'd0;
            end
            r_in_cnt  <= '0;
            r_need    <= 3'd0;
            r_idx     <= '0;
            r_acc     <= 20'sd0;
            r_hold    <= 8'd0;
            out_data  <= 16'd0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            sol_err   <= 1'b0;
        end else begin
            sol_err <= 1'b0;
            if (w_load) begin
                for (int k = 0; k < 11; k++) begin
                    r_win[k] <= in_data;
                end
                r_in_cnt <= c_CNT_W'(1);
                r_need   <= 3'd5;
                r_idx    <= '0;
            end
            if (w_shift) begin
                for (int k = 0; k < 10; k++) begin
                    r_win[k] <= r_win[k+1];
                end
                if (w_shift_real) begin
                    r_win[10] <= in_data;
                    r_in_cnt  <= r_in_cnt + c_CNT_W'(1);
                    sol_err   <= in_sol;
                end
                r_need <= r_need - 3'd1;
            end
            case (r_state)
                S_MAC0: r_acc <= (w_c5 <<< 8) + 20'sd256;
                S_MAC1: r_acc <= r_acc + 20'sd159 * w_p46;
                S_MAC2: r_acc <= r_acc - 20'sd52 * w_p28;
                S_MAC3: begin
                    r_idx <= r_idx + c_IDX_W'(1);
                    if (!r_idx[0]) begin
                        r_hold <= w_y;
                        r_need <= 3'd2;
                    end else begin
                        out_data  <= {r_hold, w_y};
                        out_valid <= 1'b1;
                        out_eol   <= (r_idx == c_LAST_IDX);
                    end
                end
                S_WRITE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_eol   <= 1'b0;
                        r_need    <= 3'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_chroma_decimate_fir.sv
// ============================================================================
// Module      : tb_chroma_decimate_fir
// Description : Directed bench for chroma_decimate_fir, default and 16-wide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chroma_decimate_fir;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sol;
    logic       out_ready;
    logic       sel;

    logic        rdy_f, ov_f, eol_f, se_f;
    logic [15:0] od_f;
    logic        rdy_s, ov_s, eol_s, se_s;
    logic [15:0] od_s;

    wire in_valid_f  = in_valid & ~sel;
    wire in_valid_s  = in_valid & sel;
    wire out_ready_f = out_ready & ~sel;
    wire out_ready_s = out_ready & sel;

    wire        rdy = sel ? rdy_s : rdy_f;
    wire        ov  = sel ? ov_s  : ov_f;
    wire        eol = sel ? eol_s : eol_f;
    wire        se  = sel ? se_s  : se_f;
    wire [15:0] od  = sel ? od_s  : od_f;

    always #5 clk = ~clk;

    chroma_decimate_fir dut_full (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .in_valid   (in_valid_f),
        .in_ready   (rdy_f),
        .in_data    (in_data),
        .in_sol     (in_sol),
        .out_valid  (ov_f),
        .out_ready  (out_ready_f),
        .out_data   (od_f),
        .out_eol    (eol_f),
        .sol_err    (se_f)
    );

    chroma_decimate_fir #(.LINE_WIDTH(16)) dut_small (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .in_valid   (in_valid_s),
        .in_ready   (rdy_s),
        .in_data    (in_data),
        .in_sol     (in_sol),
        .out_valid  (ov_s),
        .out_ready  (out_ready_s),
        .out_data   (od_s),
        .out_eol    (eol_s),
        .sol_err    (se_s)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          sol_cnt = 0;
    logic [16:0] words[$];
    logic [15:0] t2w [4] = '{16'h0214, 16'h283C, 16'h5064, 16'h778C};

    always @(negedge clk) begin
        if (ov && out_ready) words.push_back({eol, od});
        if (se) sol_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int kind, input int i);
        case (kind)
            0:       return 8'(10 * i);
            1:       return (i < 8) ? 8'd0 : 8'd255;
            default: return 8'd100;
        endcase
    endfunction

    task automatic send_sample(input logic [7:0] d, input logic s);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sol   = s;
        while (!rdy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("in_ready_timeout", guard, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sol   = 1'b0;
    endtask

    task automatic send_line(input int n, input int kind, input int sol2);
        for (int i = 0; i < n; i++) begin
            send_sample(pix(kind, i), (i == 0) || (i == sol2));
        end
    endtask

    task automatic wait_words(input int target);
        int guard = 0;
        while (words.size() < target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) chk("word_timeout", words.size(), target);
    endtask

    task automatic expect4(input string tag, input int base, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] e [4];
        e = '{w0, w1, w2, w3};
        wait_words(base + 4);
        for (int i = 0; i < 4; i++) begin
            chk(tag, words[base + i], {(i == 3), e[i]});
        end
        repeat (20) @(negedge clk);
        chk({tag, "_count"}, words.size(), base + 4);
        chk({tag, "_idle_rdy"}, rdy, 1);
    endtask

    task automatic expect_flat(input string tag, input int base);
        wait_words(base + 80);
        for (int i = 0; i < 80; i++) begin
            chk(tag, words[base + i], {(i == 79), 16'h6464});
        end
        repeat (20) @(negedge clk);
        chk({tag, "_count"}, words.size(), base + 80);
    endtask

    // Holds off each word for 10 cycles, checking it stays put and input is stalled
    task automatic stall_words(input int n);
        for (int k = 0; k < n; k++) begin
            int guard = 0;
            @(negedge clk);
            while (!ov && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 500) chk("t4_valid_timeout", guard, 0);
            repeat (10) begin
                chk("t4_hold_data", od, t2w[k]);
                chk("t4_hold_valid", ov, 1);
                chk("t4_in_ready", rdy, 0);
                @(negedge clk);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    initial begin
        int base;
        int s0;
        resetn    = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_sol    = 1'b0;
        out_ready = 1'b1;
        sel       = 1'b0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", rdy, 1);
        chk("rst_out_valid", ov, 0);
        chk("rst_out_data", od, 0);
        chk("rst_out_eol", eol, 0);
        chk("rst_sol_err", se, 0);
        chk("rst_small_in_ready", rdy_s, 1);
        @(negedge clk);
        resetn = 1'b1;

        // Constant line at default width
        base = words.size();
        s0   = sol_cnt;
        send_line(320, 2, -1);
        expect_flat("t1_word", base);
        chk("t1_sol_err", sol_cnt - s0, 0);

        // Reset part way through a line
        base = words.size();
        send_line(7, 2, -1);
        #2 resetn = 1'b0;
        #1;
        chk("t5_out_valid", ov, 0);
        chk("t5_in_ready", rdy, 1);
        chk("t5_out_data", od, 0);
        @(negedge clk);
        resetn = 1'b1;
        chk("t5_no_partial", words.size(), base);
        send_line(320, 2, -1);
        expect_flat("t5_word", base);

        // Ramp on a 16-wide line
        sel  = 1'b1;
        base = words.size();
        s0   = sol_cnt;
        send_line(16, 0, -1);
        expect4("t2_word", base, t2w[0], t2w[1], t2w[2], t2w[3]);
        chk("t2_sol_err", sol_cnt - s0, 0);

        // Step edge exercising both clip directions
        base = words.size();
        send_line(16, 1, -1);
        expect4("t3_word", base, 16'h0000, 16'h0A00, 16'hBFFF, 16'hF5FF);

        // Output backpressure
        base      = words.size();
        out_ready = 1'b0;
        fork
            send_line(16, 0, -1);
            stall_words(4);
        join
        expect4("t4_word", base, t2w[0], t2w[1], t2w[2], t2w[3]);
        out_ready = 1'b1;

        // Stray pre-line samples plus a mid-line start marker
        base = words.size();
        s0   = sol_cnt;
        send_sample(8'd200, 1'b0);
        send_sample(8'd7, 1'b0);
        send_sample(8'd55, 1'b0);
        send_line(16, 0, 6);
        expect4("t6_word", base, t2w[0], t2w[1], t2w[2], t2w[3]);
        chk("t6_sol_err_pulses", sol_cnt - s0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
